adc_spi_config: RTL and testbench

- SPI master and register sequencer that configures the SYZYGY ADC over adc_cs_n/adc_sck/adc_sdi/adc_sdo.
- On start, it plays a fixed init table of register writes. It then serves single host register write/read requests, driven from okWireIn/okTriggerIn endpoints.
- Sits beside the ADC capture path in the top level. Fully synchronous to one system-side clock.

---
 rtl/adc_spi_config.sv | 137 +++++++++++++
 tb/tb_adc_spi_config.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_config.sv
// adc_spi_config: SPI master that plays an init table into the ADC, then serves host register reads/writes.
// Define ADC_SPI_READBACK_VERIFY_EN to read back every init write and flag mismatches on init_error.
module adc_spi_config #(
  parameter int CLK_DIV  = 4,
  parameter int NUM_INIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_INIT*15-1:0] init_table,
  output logic                   init_done,
  output logic                   busy,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [6:0]             req_addr,
  input  logic [7:0]             req_wdata,
  output logic                   rsp_valid,
  output logic [7:0]             rsp_rdata,
  output logic                   init_error,
  output logic                   adc_cs_n,
  output logic                   adc_sck,
  output logic                   adc_sdi,
  input  logic                   adc_sdo
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, CS_SETUP = 3'd2, SHIFT = 3'd3, CS_HOLD = 3'd4, GAP = 3'd5;
  localparam int CW = $clog2(CLK_DIV);
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    idx, bit_idx;
  logic [15:0]   frame;
  logic [7:0]    sh_in;
  logic [14:0]   entry;
  logic          rb, last, last_entry;
  assign entry      = init_table[15*idx +: 15];
  assign last       = cnt == CW'(CLK_DIV-1);
  assign last_entry = idx == 4'(NUM_INIT-1);
  assign busy       = state != IDLE;
  assign req_ready  = state == IDLE && init_done && !start;
`ifndef ADC_SPI_READBACK_VERIFY_EN
  assign rb         = 1'b0;
  assign init_error = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      bit_idx   <= '0;
      frame     <= '0;
      sh_in     <= '0;
      init_done <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      adc_cs_n  <= 1'b1;
      adc_sck   <= 1'b0;
      adc_sdi   <= 1'b0;
`ifdef ADC_SPI_READBACK_VERIFY_EN
      rb         <= 1'b0;
      init_error <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      cnt       <= (state == IDLE || state == LOAD || last) ? '0 : cnt + 1'b1;
      case (state)
        IDLE:
          if (start) begin
            idx       <= '0;
            init_done <= 1'b0;
            state     <= LOAD;
`ifdef ADC_SPI_READBACK_VERIFY_EN
            rb         <= 1'b0;
            init_error <= 1'b0;
`endif
          end else if (req_valid && init_done) begin
            frame    <= {!req_write, req_addr, req_write ? req_wdata : 8'h00};
            adc_sdi  <= !req_write;
            adc_cs_n <= 1'b0;
            state    <= CS_SETUP;
          end
        LOAD: begin
          frame    <= {rb, entry[14:8], rb ? 8'h00 : entry[7:0]};
          adc_sdi  <= rb;
          adc_cs_n <= 1'b0;
          state    <= CS_SETUP;
        end
        CS_SETUP:
          if (last) begin
            bit_idx <= '0;
            state   <= SHIFT;
          end
        SHIFT:
          if (last) begin
            if (!adc_sck) begin
              adc_sck <= 1'b1;
              sh_in   <= {sh_in[6:0], adc_sdo};
            end else begin
              // zeros shift in behind the frame, so sdi returns low after the last bit
              adc_sck <= 1'b0;
              frame   <= {frame[14:0], 1'b0};
              adc_sdi <= frame[14];
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 4'd15) state <= CS_HOLD;
            end
          end
        CS_HOLD:
          if (last) begin
            adc_cs_n <= 1'b1;
            state    <= GAP;
          end
        GAP:
          if (last) begin
            if (init_done) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= sh_in;
              state     <= IDLE;
            end else begin
`ifdef ADC_SPI_READBACK_VERIFY_EN
              rb <= !rb;
              if (rb && sh_in != entry[7:0]) init_error <= 1'b1;
              if (!rb) state <= LOAD;
              else
`endif
              if (last_entry) begin
                init_done <= 1'b1;
                state     <= IDLE;
              end else begin
                idx   <= idx + 1'b1;
                state <= LOAD;
              end
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_spi_config.sv
// tb_adc_spi_config: scoreboard bench with an ADC register-file model on the SPI pins.
module tb_adc_spi_config;
  localparam int D = 4, N = 2;
`ifdef ADC_SPI_READBACK_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  logic clk = 0, reset = 1, start = 0, req_valid = 0, req_write = 0, adc_sdo = 0;
  logic [6:0] req_addr = 0;
  logic [7:0] req_wdata = 0;
  logic [N*15-1:0] init_table = 0;
  logic init_done, busy, req_ready, rsp_valid, init_error, adc_cs_n, adc_sck, adc_sdi;
  logic [7:0] rsp_rdata;
  int checks = 0, errors = 0;
  logic [15:0] exp_frames[$];
  int exp_rsp[$];
  logic [7:0] adc_regs[128], shadow[128];
  logic prev_cs = 1, prev_sck = 0, prev_rsp = 0, in_frame = 0;
  logic [15:0] bits = 0;
  logic [7:0] hdr = 0, v;
  int nb = 0, low_cnt = 0;
  logic [N*15-1:0] tbl0 = {15'h0214, 15'h0080};

  adc_spi_config #(.CLK_DIV(D), .NUM_INIT(N)) dut (
    .clk(clk), .reset(reset), .start(start), .init_table(init_table), .init_done(init_done),
    .busy(busy), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .init_error(init_error), .adc_cs_n(adc_cs_n), .adc_sck(adc_sck), .adc_sdi(adc_sdi), .adc_sdo(adc_sdo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ADC register 0 is modelled as a stuck register that always reads back 0x81
  function automatic logic [7:0] rd_val(input logic [6:0] a);
    return a == 7'd0 ? 8'h81 : adc_regs[a];
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      in_frame = 0; prev_cs = 1; prev_sck = 0; prev_rsp = 0; adc_sdo = 0;
    end else begin
      if (prev_cs && !adc_cs_n) begin in_frame = 1; low_cnt = 0; nb = 0; bits = 0; hdr = 0; end
      if (!adc_cs_n) low_cnt++;
      if (!prev_sck && adc_sck) begin
        bits = {bits[14:0], adc_sdi};
        nb++;
        if (nb == 8) hdr = bits[7:0];
      end
      if (busy && req_ready) chk("ready_while_busy", 1, 0);
      v = rd_val(hdr[6:0]);
      adc_sdo = (!adc_cs_n && nb >= 8 && nb < 16 && hdr[7]) ? v[(15 - nb) & 7] : 1'b0;
      if (!prev_cs && adc_cs_n && in_frame) begin
        in_frame = 0;
        chk("frame_sck_rises", nb, 16);
        chk("cs_low_cycles", low_cnt, 34 * D);
        if (exp_frames.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame: got 0x%04h expected none", bits);
        end else chk("sdi_frame", bits, exp_frames.pop_front());
        if (!bits[15]) adc_regs[bits[14:8]] = bits[7:0];
      end
      if (rsp_valid) begin
        chk("rsp_pulse_width", prev_rsp, 0);
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got 0x%02h expected none", rsp_rdata);
        end else begin
          int e;
          e = exp_rsp.pop_front();
          if (e >= 0) chk("rsp_rdata", rsp_rdata, e);
        end
      end
      prev_cs = adc_cs_n; prev_sck = adc_sck; prev_rsp = rsp_valid;
    end
  end

  task automatic wait_idle(input string name);
    int t = 0;
    while ((exp_frames.size() != 0 || exp_rsp.size() != 0 || busy) && t < 20000) begin
      @(negedge clk); t++;
    end
    chk({name, "_drained"}, t < 20000, 1);
  endtask

  task automatic run_init(input logic [N*15-1:0] tbl, input logic with_req, input logic [6:0] ra);
    int t, nf;
    logic exp_err;
    exp_err = 0;
    nf = VERIFY ? 2 * N : N;
    init_table = tbl;
    for (int i = 0; i < N; i++) begin
      logic [14:0] e;
      e = tbl[i*15 +: 15];
      exp_frames.push_back({1'b0, e});
      shadow[e[14:8]] = e[7:0];
      if (VERIFY) begin
        exp_frames.push_back({1'b1, e[14:8], 8'h00});
        if (e[14:8] == 7'd0 && e[7:0] != 8'h81) exp_err = 1;
      end
    end
    if (with_req) begin
      exp_frames.push_back({1'b1, ra, 8'h00});
      exp_rsp.push_back(int'(shadow[ra]));
    end
    @(posedge clk); #1 start = 1;
    if (with_req) begin req_valid = 1; req_write = 0; req_addr = ra; end
    @(negedge clk); chk("ready_low_on_start", req_ready, 0);
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("init_done_cleared", init_done, 0);
    t = 1;
    while (!init_done && t < 20000) begin @(negedge clk); t++; end
    chk("init_done_time", t >= nf * 35 * D && t <= nf * (35 * D + 1) + 2, 1);
    chk("init_error", init_error, exp_err);
    if (with_req) begin
      chk("req_ready_after_init", req_ready, 1);
      @(posedge clk); #1 req_valid = 0;
    end
    wait_idle("init");
    chk("init_done_held", init_done, 1);
  endtask

  task automatic host(input logic w, input logic [6:0] a, input logic [7:0] d);
    int t = 0;
    exp_frames.push_back({~w, a, w ? d : 8'h00});
    exp_rsp.push_back(w ? -1 : int'(shadow[a]));
    if (w) shadow[a] = d;
    @(posedge clk); #1 req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clk);
    while (!req_ready && t < 1000) begin @(negedge clk); t++; end
    chk("req_accept", req_ready, 1);
    @(posedge clk); #1 req_valid = 0;
    chk("busy_after_accept", busy, 1);
    wait_idle("host");
    if (!w) chk("rsp_rdata_held", rsp_rdata, shadow[a]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int t;
    for (int i = 0; i < 128; i++) begin
      adc_regs[i] = 8'($urandom);
      shadow[i] = adc_regs[i];
    end
    adc_regs[4] = 8'h5C; shadow[4] = 8'h5C;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", adc_cs_n, 1); chk("rst_sck", adc_sck, 0); chk("rst_sdi", adc_sdi, 0);
    chk("rst_busy", busy, 0); chk("rst_init_done", init_done, 0); chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0); chk("rst_rsp_rdata", rsp_rdata, 0); chk("rst_init_error", init_error, 0);
    reset = 0;
    run_init(tbl0, 1'b1, 7'h02);
    host(1'b1, 7'h03, 8'hA5);
    host(1'b0, 7'h04, 8'h00);
    host(1'b0, 7'h03, 8'h00);
    for (int i = 0; i < 10; i++) host(1'($urandom), 7'($urandom_range(3, 127)), 8'($urandom));
    run_init(tbl0, 1'b1, 7'h04);
    begin
      logic [N*15-1:0] rt;
      for (int i = 0; i < N; i++) rt[i*15 +: 15] = {7'($urandom_range(1, 127)), 8'($urandom)};
      run_init(rt, 1'b0, 7'h00);
    end
    init_table = tbl0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    t = 0;
    while (!(nb == 7 && !adc_cs_n && in_frame) && t < 2000) begin @(negedge clk); t++; end
    chk("reach_bit7", t < 2000, 1);
    #2 reset = 1;
    #1;
    chk("midrst_cs_n", adc_cs_n, 1); chk("midrst_sck", adc_sck, 0);
    chk("midrst_busy", busy, 0); chk("midrst_init_done", init_done, 0);
    exp_frames.delete(); exp_rsp.delete();
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1 reset = 0;
    run_init(tbl0, 1'b0, 7'h00);
    host(1'b0, 7'h02, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
